// File: rtl/ntsc_pkg.sv
// Shared types and sizing for the NTSC ping-pong line server.
package ntsc_pkg;
  localparam int LINE_W = 640;
  localparam int XW     = 11;
  localparam int PIX_W  = 24;
  localparam int NBANK  = 2;
  localparam int AW     = $clog2(LINE_W);

  localparam logic [XW-1:0] LAST_X = XW'(LINE_W - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;
endpackage

// File: rtl/ntsc_line_server_if.sv
// Decoder pixel stream plus row request/response bus of the line server.
interface ntsc_line_server_if;
  import ntsc_pkg::*;

  logic          in_valid;
  logic [XW-1:0] in_x;
  logic [XW-1:0] in_y;
  logic [7:0]    in_Y;
  logic [7:0]    in_Cb;
  logic [7:0]    in_Cr;
  logic          request;
  logic [XW-1:0] req_x;
  logic [XW-1:0] req_y;
  logic [7:0]    Y;
  logic [7:0]    Cb;
  logic [7:0]    Cr;
  logic          rsp_valid;
  logic          rd_underrun;
  logic          wr_drop;

  modport master (
    output in_valid, in_x, in_y, in_Y, in_Cb, in_Cr, request, req_x, req_y,
    input  Y, Cb, Cr, rsp_valid, rd_underrun, wr_drop
  );

  modport slave (
    input  in_valid, in_x, in_y, in_Y, in_Cb, in_Cr, request, req_x, req_y,
    output Y, Cb, Cr, rsp_valid, rd_underrun, wr_drop
  );
endinterface

// File: rtl/ntsc_line_server_line_ram.sv
// One line bank: simple dual-port RAM with a registered, enable-held read port.
module line_ram
  import ntsc_pkg::*;
#(
  parameter int DEPTH = LINE_W,
  parameter int ADW   = AW,
  parameter int DW    = PIX_W
) (
  input  logic           ntsc_clk,
  input  logic           we,
  input  logic [ADW-1:0] wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [ADW-1:0] rd_addr,
  output logic [DW-1:0]  rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge ntsc_clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ntsc_line_server.sv
// Ping-pong line buffer between the NTSC decoder and row requesters.
// Optional feature: define NTSC_LINE_TEST_PATTERN_EN to add the test_mode input.
module ntsc_line_server
  import ntsc_pkg::*;
(
  input  logic ntsc_clk,
  input  logic reset,
`ifdef NTSC_LINE_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  ntsc_line_server_if.slave bus
);
  bank_state_t   bank_state_q [NBANK];
  bank_state_t   bank_state_d [NBANK];
  logic [XW-1:0] tag_q [NBANK];
  logic [XW-1:0] tag_d [NBANK];
  wr_state_t     w_state_q, w_state_d;
  rd_state_t     r_state_q, r_state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          cur_bank_q, cur_bank_d;
  logic          cur_hit_q, cur_hit_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_bank_q, rsp_bank_d;
  logic          rd_underrun_q, rd_underrun_d;
  logic          wr_drop_q, wr_drop_d;
`ifdef NTSC_LINE_TEST_PATTERN_EN
  logic          pat_q, pat_d;
  logic [7:0]    pat_y_q, pat_y_d;
`endif

  logic             free_found, free_idx, hit_found, hit_idx;
  logic             wr_en, wr_sel;
  logic [PIX_W-1:0] ram_rd [NBANK];
  logic [PIX_W-1:0] rsp_pix;
  logic             in_range, rd_in_range;

  assign in_range    = bus.in_x < XW'(LINE_W);
  assign rd_in_range = bus.req_x < XW'(LINE_W);

  // Descending scan so the lowest-index bank wins both searches.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 1'b0;
    hit_found  = 1'b0;
    hit_idx    = 1'b0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (bank_state_q[i] == EMPTY) begin
        free_found = 1'b1;
        free_idx   = 1'(i);
      end
      if (bank_state_q[i] == FULL && tag_q[i] == bus.req_y) begin
        hit_found = 1'b1;
        hit_idx   = 1'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      bank_state_d[i] = bank_state_q[i];
      tag_d[i]        = tag_q[i];
    end
    w_state_d     = w_state_q;
    wr_bank_d     = wr_bank_q;
    wr_drop_d     = 1'b0;
    wr_en         = 1'b0;
    wr_sel        = wr_bank_q;
    r_state_d     = r_state_q;
    cur_bank_d    = cur_bank_q;
    cur_hit_d     = cur_hit_q;
    rsp_valid_d   = bus.request;
    rsp_zero_d    = rsp_zero_q;
    rsp_bank_d    = rsp_bank_q;
    rd_underrun_d = 1'b0;

    // Writer only moves EMPTY->FILLING->FULL, reader only FULL->READING->EMPTY,
    // so the two halves never touch the same bank in one cycle.
    if (bus.in_valid && in_range) begin
      case (w_state_q)
        W_IDLE: begin
          if (bus.in_x == '0) begin
            if (free_found) begin
              wr_en                  = 1'b1;
              wr_sel                 = free_idx;
              wr_bank_d              = free_idx;
              bank_state_d[free_idx] = FILLING;
              tag_d[free_idx]        = bus.in_y;
              w_state_d              = W_FILL;
            end else begin
              wr_drop_d = 1'b1;
            end
          end
        end
        W_FILL: begin
          wr_en = 1'b1;
          if (bus.in_x == '0) tag_d[wr_bank_q] = bus.in_y;
          if (bus.in_x == LAST_X) begin
            bank_state_d[wr_bank_q] = FULL;
            w_state_d               = W_IDLE;
          end
        end
        default: w_state_d = W_IDLE;
      endcase
    end

    if (bus.request) begin
      rsp_zero_d = 1'b1;
      if (bus.req_x == '0) begin
        // A new row start abandons any row still being read.
        if (r_state_q == R_READ && cur_hit_q) bank_state_d[cur_bank_q] = EMPTY;
        r_state_d  = R_READ;
        cur_hit_d  = hit_found;
        cur_bank_d = hit_idx;
        if (hit_found) begin
          bank_state_d[hit_idx] = READING;
          rsp_zero_d            = 1'b0;
          rsp_bank_d            = hit_idx;
        end else begin
          rd_underrun_d = 1'b1;
        end
      end else if (r_state_q == R_READ) begin
        rsp_zero_d = !cur_hit_q || !rd_in_range;
        rsp_bank_d = cur_bank_q;
        if (bus.req_x == LAST_X) begin
          r_state_d = R_IDLE;
          cur_hit_d = 1'b0;
          if (cur_hit_q) bank_state_d[cur_bank_q] = EMPTY;
        end
      end
    end

`ifdef NTSC_LINE_TEST_PATTERN_EN
    pat_d   = pat_q;
    pat_y_d = pat_y_q;
    if (test_mode) rd_underrun_d = 1'b0;
    if (bus.request) begin
      pat_d   = test_mode;
      pat_y_d = bus.req_x[7:0] ^ bus.req_y[7:0];
    end
`endif
  end

  always_ff @(posedge ntsc_clk) begin
    if (reset) begin
      for (int i = 0; i < NBANK; i++) begin
        bank_state_q[i] <= EMPTY;
        tag_q[i]        <= '0;
      end
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      wr_bank_q     <= 1'b0;
      cur_bank_q    <= 1'b0;
      cur_hit_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_zero_q    <= 1'b1;
      rsp_bank_q    <= 1'b0;
      rd_underrun_q <= 1'b0;
      wr_drop_q     <= 1'b0;
`ifdef NTSC_LINE_TEST_PATTERN_EN
      pat_q         <= 1'b0;
      pat_y_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        bank_state_q[i] <= bank_state_d[i];
        tag_q[i]        <= tag_d[i];
      end
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      wr_bank_q     <= wr_bank_d;
      cur_bank_q    <= cur_bank_d;
      cur_hit_q     <= cur_hit_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_bank_q    <= rsp_bank_d;
      rd_underrun_q <= rd_underrun_d;
      wr_drop_q     <= wr_drop_d;
`ifdef NTSC_LINE_TEST_PATTERN_EN
      pat_q         <= pat_d;
      pat_y_q       <= pat_y_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    line_ram u_ram (
      .ntsc_clk (ntsc_clk),
      .we       (wr_en && (wr_sel == 1'(gi))),
      .wr_addr  (bus.in_x[AW-1:0]),
      .wr_data  ({bus.in_Y, bus.in_Cb, bus.in_Cr}),
      .rd_en    (bus.request),
      .rd_addr  (bus.req_x[AW-1:0]),
      .rd_data  (ram_rd[gi])
    );
  end

  // RAM output and select flops only move on a request, so data holds otherwise.
  always_comb begin
    rsp_pix = rsp_zero_q ? '0 : ram_rd[rsp_bank_q];
`ifdef NTSC_LINE_TEST_PATTERN_EN
    if (pat_q) rsp_pix = {pat_y_q, 8'h80, 8'h80};
`endif
  end

  assign bus.Y           = rsp_pix[23:16];
  assign bus.Cb          = rsp_pix[15:8];
  assign bus.Cr          = rsp_pix[7:0];
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rd_underrun = rd_underrun_q;
  assign bus.wr_drop     = wr_drop_q;
endmodule
